// File: rtl/slap_colour_mixer.sv
// Final video mixer: priority-merges FG/SP/BG indices, looks them up in three downloadable colour PROMs,
// and emits registered RGB with aligned blanking. Optional layer masking is enabled by MIXER_LAYER_MASK_EN.
module slap_colour_mixer #(
    parameter int PROM_AW  = 8,
    parameter int COLOR_W  = 4,
    parameter int TRANSP_W = 4
) (
    input  logic               master_clk,
    input  logic               nRESET,
    input  logic               pixel_ce,
    input  logic [7:0]         SP_PIX,
    input  logic [7:0]         FG_PIX,
    input  logic [7:0]         BG_PIX,
    input  logic               HBLANK,
    input  logic               VBLANK,
    input  logic [24:0]        dn_addr,
    input  logic [7:0]         dn_data,
    input  logic               dn_wr,
    input  logic               prom_r_cs,
    input  logic               prom_g_cs,
    input  logic               prom_b_cs,
`ifdef MIXER_LAYER_MASK_EN
    input  logic [2:0]         layer_en,
`endif
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic               HBLANK_O,
    output logic               VBLANK_O
);

    localparam logic [1:0] ST_WAIT_VB = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;

    localparam int PROM_DEPTH = 2 ** PROM_AW;

    logic [1:0] state_q, state_d;

    logic [7:0] sp_q, sp_d, fg_q, fg_d, bg_q, bg_d;
    logic       hb1_q, hb1_d, vb1_q, vb1_d;

    logic [7:0] idx_q, idx_d;
    logic       hb2_q, hb2_d, vb2_q, vb2_d;

    logic [COLOR_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
    logic               hbo_q, hbo_d, vbo_q, vbo_d;

    logic [COLOR_W-1:0] prom_r [PROM_DEPTH];
    logic [COLOR_W-1:0] prom_g [PROM_DEPTH];
    logic [COLOR_W-1:0] prom_b [PROM_DEPTH];
    logic [COLOR_W-1:0] rdata_r, rdata_g, rdata_b;

    logic [PROM_AW-1:0] wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic [PROM_AW-1:0] rd_addr;
    logic               any_cs;
    logic               vb_rise;
    logic               fg_vis, sp_vis;
    logic [7:0]         bg_idx;
    logic               unused_dn;

    assign wr_addr   = dn_addr[PROM_AW-1:0];
    assign wr_data   = dn_data[COLOR_W-1:0];
    assign rd_addr   = idx_q[PROM_AW-1:0];
    assign any_cs    = prom_r_cs | prom_g_cs | prom_b_cs;
    assign unused_dn = ^{dn_addr[24:PROM_AW], dn_data[7:COLOR_W]};

    // Rising edge of the S1 VBLANK register, seen at the moment it loads.
    assign vb_rise = pixel_ce & VBLANK & ~vb1_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_VB: begin
                if (any_cs)       state_d = ST_LOAD;
                else if (vb_rise) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (any_cs) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!any_cs) state_d = ST_WAIT_VB;
            end
            default: state_d = ST_WAIT_VB;
        endcase
    end

    always_comb begin
        sp_d  = sp_q;
        fg_d  = fg_q;
        bg_d  = bg_q;
        hb1_d = hb1_q;
        vb1_d = vb1_q;
        if (pixel_ce) begin
            sp_d  = SP_PIX;
            fg_d  = FG_PIX;
            bg_d  = BG_PIX;
            hb1_d = HBLANK;
            vb1_d = VBLANK;
        end
    end

    always_comb begin
        fg_vis = |fg_q[TRANSP_W-1:0];
        sp_vis = |sp_q[TRANSP_W-1:0];
        bg_idx = bg_q;
`ifdef MIXER_LAYER_MASK_EN
        fg_vis = fg_vis & layer_en[2];
        sp_vis = sp_vis & layer_en[1];
        bg_idx = layer_en[0] ? bg_q : 8'h00;
`endif
        idx_d = idx_q;
        hb2_d = hb2_q;
        vb2_d = vb2_q;
        if (pixel_ce) begin
            idx_d = fg_vis ? fg_q : (sp_vis ? sp_q : bg_idx);
            hb2_d = hb1_q;
            vb2_d = vb1_q;
        end
    end

    // Blanking always follows the pipeline; only colour is gated by the sequencer.
    always_comb begin
        red_d = red_q;
        grn_d = grn_q;
        blu_d = blu_q;
        hbo_d = hbo_q;
        vbo_d = vbo_q;
        if (pixel_ce) begin
            hbo_d = hb2_q;
            vbo_d = vb2_q;
            if (hb2_q || vb2_q || (state_q != ST_RUN)) begin
                red_d = '0;
                grn_d = '0;
                blu_d = '0;
            end else begin
                red_d = rdata_r;
                grn_d = rdata_g;
                blu_d = rdata_b;
            end
        end
    end

    always_ff @(posedge master_clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_WAIT_VB;
            sp_q    <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            hb1_q   <= 1'b1;
            vb1_q   <= 1'b1;
            idx_q   <= '0;
            hb2_q   <= 1'b1;
            vb2_q   <= 1'b1;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
            hbo_q   <= 1'b1;
            vbo_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            hb1_q   <= hb1_d;
            vb1_q   <= vb1_d;
            idx_q   <= idx_d;
            hb2_q   <= hb2_d;
            vb2_q   <= vb2_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
            hbo_q   <= hbo_d;
            vbo_q   <= vbo_d;
        end
    end

    // PROM storage is not reset; contents come only from the download port.
    always_ff @(posedge master_clk) begin
        if (dn_wr && prom_r_cs) prom_r[wr_addr] <= wr_data;
        if (dn_wr && prom_g_cs) prom_g[wr_addr] <= wr_data;
        if (dn_wr && prom_b_cs) prom_b[wr_addr] <= wr_data;
        rdata_r <= prom_r[rd_addr];
        rdata_g <= prom_g[rd_addr];
        rdata_b <= prom_b[rd_addr];
    end

    assign RED      = red_q;
    assign GREEN    = grn_q;
    assign BLUE     = blu_q;
    assign HBLANK_O = hbo_q;
    assign VBLANK_O = vbo_q;

endmodule

// File: tb/tb_slap_colour_mixer.sv
// Randomized bench for slap_colour_mixer: per-pixel comparison against a queue-based reference model.
// Define MIXER_LAYER_MASK_EN to also exercise the layer mask.
module tb_slap_colour_mixer;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        pixel_ce = 1'b0;
    logic [7:0]  SP_PIX = '0, FG_PIX = '0, BG_PIX = '0;
    logic        HBLANK = 1'b0, VBLANK = 1'b0;
    logic [24:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        dn_wr = 1'b0;
    logic        prom_r_cs = 1'b0, prom_g_cs = 1'b0, prom_b_cs = 1'b0;
    logic [2:0]  layer_en = 3'b111;
    logic [3:0]  RED, GREEN, BLUE;
    logic        HBLANK_O, VBLANK_O;

    always #5 clk = ~clk;

    slap_colour_mixer dut (
        .master_clk(clk),
        .nRESET(nRESET),
        .pixel_ce(pixel_ce),
        .SP_PIX(SP_PIX),
        .FG_PIX(FG_PIX),
        .BG_PIX(BG_PIX),
        .HBLANK(HBLANK),
        .VBLANK(VBLANK),
        .dn_addr(dn_addr),
        .dn_data(dn_data),
        .dn_wr(dn_wr),
        .prom_r_cs(prom_r_cs),
        .prom_g_cs(prom_g_cs),
        .prom_b_cs(prom_b_cs),
`ifdef MIXER_LAYER_MASK_EN
        .layer_en(layer_en),
`endif
        .RED(RED),
        .GREEN(GREEN),
        .BLUE(BLUE),
        .HBLANK_O(HBLANK_O),
        .VBLANK_O(VBLANK_O)
    );

    typedef struct {
        logic [7:0] sp, fg, bg;
        logic       hb, vb;
        logic [2:0] len;
    } pix_t;

    // Reference model: colour tables, pixels in flight, and whether the display is live.
    logic [3:0] mr [256];
    logic [3:0] mg [256];
    logic [3:0] mb [256];
    pix_t       pix_q[$];
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;
    bit         run_m;
    bit         vb_prev_m;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] winner(input pix_t p);
        if (p.len[2] && p.fg[3:0] != 4'h0) return p.fg;
        if (p.len[1] && p.sp[3:0] != 4'h0) return p.sp;
        return p.len[0] ? p.bg : 8'h00;
    endfunction

    function automatic logic [13:0] dut_out();
        return {RED, GREEN, BLUE, HBLANK_O, VBLANK_O};
    endfunction

    task automatic model_reset();
        pix_t z;
        z.sp = '0; z.fg = '0; z.bg = '0; z.hb = 1'b1; z.vb = 1'b1; z.len = 3'b111;
        pix_q.delete();
        pix_q.push_back(z);
        pix_q.push_back(z);
        run_m = 0;
        vb_prev_m = 1;
        last_exp = 14'h3;
    endtask

    // One pixel: a pixel_ce clock followed by a plain clock.
    task automatic pix(input string tag, input logic [7:0] sp, fg, bg, input logic hb, vb);
        pix_t p;
        pix_t o;
        logic [7:0] w;
        logic [11:0] rgb;
        SP_PIX = sp; FG_PIX = fg; BG_PIX = bg; HBLANK = hb; VBLANK = vb;
        pixel_ce = 1'b1;
        @(posedge clk);
        #1;
        pixel_ce = 1'b0;
        pix_q[pix_q.size()-1].len = layer_en;
        p.sp = sp; p.fg = fg; p.bg = bg; p.hb = hb; p.vb = vb; p.len = 3'b111;
        pix_q.push_back(p);
        o = pix_q.pop_front();
        w = winner(o);
        rgb = (o.hb || o.vb || !run_m) ? 12'h000 : {mr[w], mg[w], mb[w]};
        exp_q.push_back({rgb, o.hb, o.vb});
        if (vb && !vb_prev_m) run_m = 1;
        vb_prev_m = vb;
        last_exp = exp_q.pop_front();
        check(tag, dut_out(), last_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pix(input string tag, input logic hb, vb);
        logic [7:0] sp, fg, bg;
        fg = $urandom_range(0, 255);
        sp = $urandom_range(0, 255);
        bg = $urandom_range(0, 255);
        if ($urandom_range(0, 2) == 0) fg[3:0] = 4'h0;
        if ($urandom_range(0, 2) == 0) sp[3:0] = 4'h0;
        pix(tag, sp, fg, bg, hb, vb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("freeze", dut_out(), last_exp);
        end
    endtask

    task automatic prom_write(input logic [7:0] a, input logic [3:0] d, input logic [2:0] cs);
        dn_addr = {17'h0, a};
        dn_data = {$urandom_range(0, 15), d};
        {prom_b_cs, prom_g_cs, prom_r_cs} = cs;
        dn_wr = 1'b1;
        @(posedge clk);
        #1;
        dn_wr = 1'b0;
        {prom_b_cs, prom_g_cs, prom_r_cs} = 3'b000;
        if (cs[0]) mr[a] = d;
        if (cs[1]) mg[a] = d;
        if (cs[2]) mb[a] = d;
        run_m = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic vblank_pulse(input string tag);
        for (int i = 0; i < 3; i++) rand_pix(tag, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) rand_pix(tag, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", {RED, GREEN, BLUE}, 12'h000);
        check("reset_blank", {HBLANK_O, VBLANK_O}, 2'b11);
        nRESET = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < 256; a++)
            for (int c = 0; c < 3; c++)
                prom_write(a[7:0], $urandom_range(0, 15), 3'b001 << c);
        prom_write(8'h25, 4'hA, 3'b001);
        prom_write(8'h25, 4'h5, 3'b010);
        prom_write(8'h25, 4'hF, 3'b100);
        prom_write(8'h30, 4'h9, 3'b111);

        for (int i = 0; i < 4; i++) rand_pix("pre_vb", 1'b0, 1'b0);
        check("pre_vb_black", {RED, GREEN, BLUE}, 12'h000);
        vblank_pulse("vb1");

        pix("t1", 8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
        pix("t1", 8'h00, 8'h00, 8'h30, 1'b0, 1'b0);
        pix("t1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("t1_a5f", {RED, GREEN, BLUE}, 12'hA5F);
        pix("t1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("t1_multi_cs", {RED, GREEN, BLUE}, 12'h999);

        pix("t2", 8'h47, 8'h13, 8'h25, 1'b0, 1'b0);
        pix("t2", 8'h47, 8'h10, 8'h25, 1'b0, 1'b0);
        pix("t2", 8'h40, 8'h10, 8'h25, 1'b0, 1'b0);
        pix("t2", 8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
        pix("t2", 8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
        check("t2_bg_wins", {RED, GREEN, BLUE}, 12'hA5F);

        for (int i = 0; i < 3; i++) pix("t3", 8'h47, 8'h13, 8'h25, 1'b1, 1'b0);
        check("t3_hb_black", dut_out(), 14'h2);
        for (int i = 0; i < 3; i++) pix("t3", 8'h00, 8'h00, 8'h25, 1'b0, 1'b0);
        check("t3_release", dut_out(), {12'hA5F, 2'b00});

        for (int i = 0; i < 60; i++) rand_pix("line", ($urandom_range(0, 7) == 0), 1'b0);

        for (int i = 0; i < 6; i++) begin
            rand_pix("t5", 1'b0, 1'b0);
            idle(10);
        end

        prom_g_cs = 1'b1;
        @(posedge clk);
        #1;
        run_m = 0;
        rand_pix("t4_load", 1'b0, 1'b0);
        check("t4_black", {RED, GREEN, BLUE}, 12'h000);
        prom_g_cs = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) rand_pix("t4_wait", 1'b0, 1'b0);
        vblank_pulse("t4_vb");
        for (int i = 0; i < 20; i++) rand_pix("t4_run", ($urandom_range(0, 7) == 0), 1'b0);

        rand_pix("t6_pre", 1'b0, 1'b0);
        nRESET = 1'b0;
        #1;
        check("t6_async_rgb", {RED, GREEN, BLUE}, 12'h000);
        check("t6_async_blank", {HBLANK_O, VBLANK_O}, 2'b11);
        @(posedge clk);
        #1;
        nRESET = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) rand_pix("t6_wait", 1'b0, 1'b0);
        vblank_pulse("t6_vb");
        for (int i = 0; i < 20; i++) rand_pix("t6_run", 1'b0, 1'b0);

`ifdef MIXER_LAYER_MASK_EN
        layer_en = 3'b011;
        for (int i = 0; i < 3; i++) pix("t7_011", 8'h47, 8'h13, 8'h25, 1'b0, 1'b0);
        check("t7_sp_wins", {RED, GREEN, BLUE}, {mr[8'h47], mg[8'h47], mb[8'h47]});
        layer_en = 3'b000;
        for (int i = 0; i < 3; i++) pix("t7_000", 8'h47, 8'h13, 8'h25, 1'b0, 1'b0);
        check("t7_zero", {RED, GREEN, BLUE}, {mr[8'h00], mg[8'h00], mb[8'h00]});
        for (int i = 0; i < 30; i++) begin
            layer_en = $urandom_range(0, 7);
            rand_pix("t7_rand", 1'b0, 1'b0);
        end
        layer_en = 3'b111;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
